// File: rtl/rs_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_arbiter_if
// Description : Bundle between the reservation station and the issue arbiter.
//               The master side (RS) drives the readiness view and the stall.
//               The slave side (arbiter) returns the registered grants, the
//               row clear mask and the per-FU free flags.
//   i_ready        RS_ENTRIES  row in_use & Src0Ready & Src1Ready
//   i_is_mem       RS_ENTRIES  row is LW/SW (memory FU only)
//   i_stall        1           suppress new grants this cycle
//   o_grant_valid  3           bit k = FU k granted
//   o_grant_idx    3*IDX_W     RS row for FU k at [k*IDX_W +: IDX_W]
//   o_clear        RS_ENTRIES  rows released this cycle
//   o_fu_free      3           bit k = FU k idle
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_issue_arbiter_if #(
    parameter int RS_ENTRIES = 16,
    parameter int IDX_W      = 4
);
    logic [RS_ENTRIES-1:0] i_ready;
    logic [RS_ENTRIES-1:0] i_is_mem;
    logic                  i_stall;
    logic [2:0]            o_grant_valid;
    logic [3*IDX_W-1:0]    o_grant_idx;
    logic [RS_ENTRIES-1:0] o_clear;
    logic [2:0]            o_fu_free;

    modport master (
        output i_ready,
        output i_is_mem,
        output i_stall,
        input  o_grant_valid,
        input  o_grant_idx,
        input  o_clear,
        input  o_fu_free
    );

    modport slave (
        input  i_ready,
        input  i_is_mem,
        input  i_stall,
        output o_grant_valid,
        output o_grant_idx,
        output o_clear,
        output o_fu_free
    );
endinterface
`default_nettype wire

// File: rtl/rs_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_arbiter
// Description : Issue scheduler for the reservation station. Each cycle it
//               selects at most one ready row per functional unit (FU0/FU1 =
//               ALUs, FU2 = LW/SW unit), tracks FU occupancy with busy
//               counters and keeps fairness with round-robin scan pointers.
//               Grants and the row clear mask are registered (1-cycle
//               latency from i_ready).
// Ports       : i_clk   clock, all state on rising edge
//               i_rst   asynchronous active-high reset
//               bus     rs_issue_arbiter_if.slave (ready/is_mem/stall in,
//                       grant_valid/grant_idx/clear/fu_free out)
// Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_arbiter #(
    parameter int RS_ENTRIES = 16,
    parameter int IDX_W      = 4,
    parameter int ALU_LAT    = 1,
    parameter int MEM_LAT    = 3,
    parameter int CNT_W      = 2
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    rs_issue_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0]      c_alu_load = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0]      c_mem_load = CNT_W'(MEM_LAT - 1);
    localparam logic [RS_ENTRIES-1:0] c_one_hot  = RS_ENTRIES'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      r_cnt [3];
    logic [IDX_W-1:0]      r_alu_ptr;
    logic [IDX_W-1:0]      r_mem_ptr;
    logic [2:0]            r_grant_valid;
    logic [3*IDX_W-1:0]    r_grant_idx;
    logic [RS_ENTRIES-1:0] r_clear;

    // ------------------------------------------------------------------
    // Eligibility: rows granted on the last edge are still shown ready by
    // the RS for one cycle, so they are masked to avoid double issue.
    // ------------------------------------------------------------------
    logic [RS_ENTRIES-1:0] w_elig;
    logic [RS_ENTRIES-1:0] w_alu_elig;
    logic [RS_ENTRIES-1:0] w_mem_elig;

    assign w_elig     = bus.i_ready & ~r_clear;
    assign w_alu_elig = w_elig & ~bus.i_is_mem;
    assign w_mem_elig = w_elig &  bus.i_is_mem;

    logic [2:0] w_fu_idle;

    assign w_fu_idle[0] = (r_cnt[0] == '0);
    assign w_fu_idle[1] = (r_cnt[1] == '0);
    assign w_fu_idle[2] = (r_cnt[2] == '0);

    // ------------------------------------------------------------------
    // Round-robin scans. The ALU scan yields the first and second eligible
    // rows starting at r_alu_ptr; the memory scan yields the first row
    // starting at r_mem_ptr. Pointer + offset wraps naturally because
    // RS_ENTRIES is a power of two.
    // ------------------------------------------------------------------
    logic             w_alu_hit0;
    logic             w_alu_hit1;
    logic [IDX_W-1:0] w_alu_row0;
    logic [IDX_W-1:0] w_alu_row1;
    logic             w_mem_hit;
    logic [IDX_W-1:0] w_mem_row;
    logic [IDX_W-1:0] w_pos_a;
    logic [IDX_W-1:0] w_pos_m;

    always_comb begin
        w_alu_hit0 = 1'b0;
        w_alu_hit1 = 1'b0;
        w_alu_row0 = '0;
        w_alu_row1 = '0;
        w_mem_hit  = 1'b0;
        w_mem_row  = '0;
        w_pos_a    = '0;
        w_pos_m    = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_pos_a = r_alu_ptr + IDX_W'(i);
            w_pos_m = r_mem_ptr + IDX_W'(i);
            if (w_alu_elig[w_pos_a]) begin
                if (!w_alu_hit0) begin
                    w_alu_hit0 = 1'b1;
                    w_alu_row0 = w_pos_a;
                end else if (!w_alu_hit1) begin
                    w_alu_hit1 = 1'b1;
                    w_alu_row1 = w_pos_a;
                end
            end
            if (w_mem_elig[w_pos_m] && !w_mem_hit) begin
                w_mem_hit = 1'b1;
                w_mem_row = w_pos_m;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant decision. When only one ALU is idle it takes the first row in
    // scan order, so the second row is used only when both ALUs are idle.
    // Distinct scan positions guarantee no row appears twice.
    // ------------------------------------------------------------------
    logic [2:0]            w_gnt;
    logic [IDX_W-1:0]      w_gnt_idx [3];
    logic [RS_ENTRIES-1:0] w_clear_nxt;

    always_comb begin
        w_gnt        = 3'b000;
        w_gnt_idx[0] = '0;
        w_gnt_idx[1] = '0;
        w_gnt_idx[2] = '0;
        if (!bus.i_stall) begin
            if (w_fu_idle[0] && w_fu_idle[1]) begin
                w_gnt[0]     = w_alu_hit0;
                w_gnt_idx[0] = w_alu_row0;
                w_gnt[1]     = w_alu_hit1;
                w_gnt_idx[1] = w_alu_row1;
            end else if (w_fu_idle[0]) begin
                w_gnt[0]     = w_alu_hit0;
                w_gnt_idx[0] = w_alu_row0;
            end else if (w_fu_idle[1]) begin
                w_gnt[1]     = w_alu_hit0;
                w_gnt_idx[1] = w_alu_row0;
            end
            if (w_fu_idle[2]) begin
                w_gnt[2]     = w_mem_hit;
                w_gnt_idx[2] = w_mem_row;
            end
        end
    end

    always_comb begin
        w_clear_nxt = '0;
        for (int k = 0; k < 3; k++) begin
            if (w_gnt[k]) begin
                w_clear_nxt = w_clear_nxt | (c_one_hot << w_gnt_idx[k]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy counters: load LAT-1 on grant, otherwise count down to zero.
    // A zero counter means the FU can accept an issue this cycle.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_cnt_nxt [3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (w_gnt[k]) begin
                w_cnt_nxt[k] = (k == 2) ? c_mem_load : c_alu_load;
            end else if (r_cnt[k] != '0) begin
                w_cnt_nxt[k] = r_cnt[k] - CNT_W'(1);
            end else begin
                w_cnt_nxt[k] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt[0]      <= '0;
            r_cnt[1]      <= '0;
            r_cnt[2]      <= '0;
            r_alu_ptr     <= '0;
            r_mem_ptr     <= '0;
            r_grant_valid <= 3'b000;
            r_grant_idx   <= '0;
            r_clear       <= '0;
        end else begin
            r_cnt[0]      <= w_cnt_nxt[0];
            r_cnt[1]      <= w_cnt_nxt[1];
            r_cnt[2]      <= w_cnt_nxt[2];
            r_grant_valid <= w_gnt;
            r_clear       <= w_clear_nxt;

            // Index fields only move on a grant; consumers qualify with valid.
            if (w_gnt[0]) r_grant_idx[0*IDX_W +: IDX_W] <= w_gnt_idx[0];
            if (w_gnt[1]) r_grant_idx[1*IDX_W +: IDX_W] <= w_gnt_idx[1];
            if (w_gnt[2]) r_grant_idx[2*IDX_W +: IDX_W] <= w_gnt_idx[2];

            // The ALU pointer follows the later of the two ALU grants in
            // scan order, which is FU1's whenever FU1 issued.
            if (w_gnt[1]) begin
                r_alu_ptr <= w_gnt_idx[1] + IDX_W'(1);
            end else if (w_gnt[0]) begin
                r_alu_ptr <= w_gnt_idx[0] + IDX_W'(1);
            end
            if (w_gnt[2]) begin
                r_mem_ptr <= w_gnt_idx[2] + IDX_W'(1);
            end
        end
    end

    assign bus.o_grant_valid = r_grant_valid;
    assign bus.o_grant_idx   = r_grant_idx;
    assign bus.o_clear       = r_clear;
    assign bus.o_fu_free     = w_fu_idle;

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_issue_arbiter
// Description : Scoreboard bench for rs_issue_arbiter. A stimulus process
//               drives directed scenarios followed by random traffic, runs a
//               list-based reference model and queues the expected outputs;
//               a monitor process pops one record per clock and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_issue_arbiter;

    localparam int N     = 16;
    localparam int IW    = 4;
    localparam int A_LAT = 1;
    localparam int M_LAT = 3;

    logic clk;
    logic rst;

    rs_issue_arbiter_if #(.RS_ENTRIES(N), .IDX_W(IW)) bus ();

    rs_issue_arbiter #(
        .RS_ENTRIES(N), .IDX_W(IW), .ALU_LAT(A_LAT), .MEM_LAT(M_LAT), .CNT_W(2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]      valid;
        logic [3*IW-1:0] idx;
        logic [N-1:0]    clr;
        logic [2:0]      free;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int           m_ptr_a;
    int           m_ptr_m;
    int           m_cnt [3];
    logic [N-1:0] m_clear;
    int           m_idx [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr_a = 0;
        m_ptr_m = 0;
        m_clear = '0;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_idx[k] = 0;
        end
    endtask

    // Computes what the DUT shows after the next edge for these inputs.
    task automatic model_step(input logic [N-1:0] rdy, input logic [N-1:0] mem, input logic stall);
        int           alu_list[$];
        int           mem_list[$];
        int           taken;
        logic [2:0]   v;
        logic [N-1:0] elig;
        logic [N-1:0] clr;
        exp_t         e;
        elig  = rdy & ~m_clear;
        for (int n = 0; n < N; n++) begin
            int r;
            r = (m_ptr_a + n) % N;
            if (elig[r] && !mem[r]) alu_list.push_back(r);
            r = (m_ptr_m + n) % N;
            if (elig[r] && mem[r]) mem_list.push_back(r);
        end
        v     = 3'b000;
        taken = 0;
        if (!stall) begin
            for (int k = 0; k < 2; k++) begin
                if (m_cnt[k] == 0 && alu_list.size() > taken) begin
                    v[k]     = 1'b1;
                    m_idx[k] = alu_list[taken];
                    taken++;
                end
            end
            if (m_cnt[2] == 0 && mem_list.size() > 0) begin
                v[2]     = 1'b1;
                m_idx[2] = mem_list[0];
            end
        end
        clr = '0;
        for (int k = 0; k < 3; k++) begin
            if (v[k]) begin
                m_cnt[k] = (k == 2) ? M_LAT - 1 : A_LAT - 1;
                clr[m_idx[k]] = 1'b1;
            end else if (m_cnt[k] > 0) begin
                m_cnt[k] = m_cnt[k] - 1;
            end
        end
        if (v[1])      m_ptr_a = (m_idx[1] + 1) % N;
        else if (v[0]) m_ptr_a = (m_idx[0] + 1) % N;
        if (v[2])      m_ptr_m = (m_idx[2] + 1) % N;
        m_clear = clr;
        e.valid = v;
        e.idx   = {IW'(m_idx[2]), IW'(m_idx[1]), IW'(m_idx[0])};
        e.clr   = clr;
        e.free  = {m_cnt[2] == 0, m_cnt[1] == 0, m_cnt[0] == 0};
        q.push_back(e);
    endtask

    task automatic cycle(input logic [N-1:0] rdy, input logic [N-1:0] mem, input logic stall);
        @(posedge clk);
        #2;
        bus.i_ready  = rdy;
        bus.i_is_mem = mem;
        bus.i_stall  = stall;
        model_step(rdy, mem, stall);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        bus.i_ready  = '0;
        bus.i_is_mem = '0;
        bus.i_stall  = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_fu_free", 32'(bus.o_fu_free), 32'h7);
        chk("rst_valid",   32'(bus.o_grant_valid), 32'h0);
        chk("rst_clear",   32'(bus.o_clear), 32'h0);
        q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one expected record per clock after each registered update.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant_valid", 32'(bus.o_grant_valid), 32'(e.valid));
                chk("grant_idx",   32'(bus.o_grant_idx),   32'(e.idx));
                chk("clear",       32'(bus.o_clear),       32'(e.clr));
                chk("fu_free",     32'(bus.o_fu_free),     32'(e.free));
            end
        end
    end

    initial begin
        logic [N-1:0] rdy;
        logic [N-1:0] mem;
        rst          = 1'b1;
        bus.i_ready  = '0;
        bus.i_is_mem = '0;
        bus.i_stall  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_fu_free", 32'(bus.o_fu_free), 32'h7);
        chk("init_valid",   32'(bus.o_grant_valid), 32'h0);
        chk("init_idx",     32'(bus.o_grant_idx), 32'h0);
        chk("init_clear",   32'(bus.o_clear), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Dual ALU issue, then the same rows masked the following cycle
        cycle(16'h0006, 16'h0000, 1'b0);
        cycle(16'h0006, 16'h0000, 1'b0);
        cycle(16'h0000, 16'h0000, 1'b0);

        // Memory FU occupancy
        async_reset();
        repeat (7) cycle(16'h0011, 16'h0011, 1'b0);

        // Round-robin wrap: steer alu_ptr to 14 first
        async_reset();
        cycle(16'h2000, 16'h0000, 1'b0);
        cycle(16'h8003, 16'h0000, 1'b0);
        cycle(16'h0006, 16'h0000, 1'b0);

        // Stall with memory FU busy
        async_reset();
        cycle(16'h0100, 16'h0100, 1'b0);
        cycle(16'h00FF, 16'h0000, 1'b1);
        cycle(16'h00FF, 16'h0000, 1'b1);
        cycle(16'h00FF, 16'h0000, 1'b0);
        cycle(16'h0000, 16'h0000, 1'b0);

        // Mixed full load
        async_reset();
        cycle(16'hFFFF, 16'hF000, 1'b0);
        cycle(16'hFFFF, 16'hF000, 1'b0);

        // Reset while the memory FU counter is nonzero
        cycle(16'h0001, 16'h0001, 1'b0);
        async_reset();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       rdy = N'($urandom);
                1:       rdy = N'($urandom & $urandom);
                2:       rdy = N'($urandom & $urandom & $urandom);
                default: rdy = N'(16'h1 << $urandom_range(0, N - 1));
            endcase
            mem = N'($urandom);
            cycle(rdy, mem, $urandom_range(0, 7) == 0);
        end

        repeat (3) cycle(16'h0000, 16'h0000, 1'b0);
        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
